// File: rtl/bram9_rd_pkg.sv
// Shared types and sizing for the block-RAM stream reader.
// Imported by the FIFO and the top level.
package bram9_rd_pkg;

    localparam int unsigned ADDR_W     = 11;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 3;
    localparam int unsigned CNT_W      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              par;
        logic              last;
    } fifo_entry_t;

    // Pointer increment modulo FIFO_DEPTH (depth is not a power of two).
    function automatic logic [CNT_W-1:0] ptr_next(input logic [CNT_W-1:0] p);
        return (p == CNT_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/bram9_stream_reader_if.sv
// Command, RAM read-port and output-stream signals of the reader.
// The master modport is the reader's view; slave is the environment's view.
interface bram9_stream_reader_if;
    import bram9_rd_pkg::*;

    logic              cmd_val;
    logic              cmd_rdy;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_cnt;

    logic              bram_en;
    logic              bram_we;
    logic              bram_ssr;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_do;
    logic              bram_dop;

    logic              out_val;
    logic              out_rdy;
    logic [DATA_W-1:0] out_data;
    logic              out_par;
    logic              out_last;
    logic              out_perr;

    modport master (
        input  cmd_val, cmd_addr, cmd_cnt, bram_do, bram_dop, out_rdy,
        output cmd_rdy, bram_en, bram_we, bram_ssr, bram_addr,
               out_val, out_data, out_par, out_last, out_perr
    );

    modport slave (
        output cmd_val, cmd_addr, cmd_cnt, bram_do, bram_dop, out_rdy,
        input  cmd_rdy, bram_en, bram_we, bram_ssr, bram_addr,
               out_val, out_data, out_par, out_last, out_perr
    );

endinterface

// File: rtl/bram9_rd_fifo.sv
// Three-entry synchronous FIFO holding {data, parity, last} read beats.
// Storage is cleared on reset so the head reads as zero when idle.
module bram9_rd_fifo
    import bram9_rd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  fifo_entry_t      push_data_i,
    input  logic             pop_i,
    output fifo_entry_t      head_o,
    output logic [CNT_W-1:0] count_o
);

    fifo_entry_t      mem_q [FIFO_DEPTH];
    logic [CNT_W-1:0] wr_q;
    logic [CNT_W-1:0] rd_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= ptr_next(wr_q);
            end
            if (pop_i) begin
                rd_q <= ptr_next(rd_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/bram9_stream_reader.sv
// Burst reader for the 2Kx9 block RAM: issues reads under a 3-credit limit and streams bytes out.
// Optional parity checker enabled by defining BRAM9_RD_PARITY_CHK_EN.
module bram9_stream_reader
    import bram9_rd_pkg::*;
#(
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    bram9_stream_reader_if.master bus,
    output logic                  err_sticky,
    output logic                  busy
);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rem_q;
    logic              inflight_q;
    logic              inflight_last_q;

    fifo_entry_t       head;
    fifo_entry_t       push_entry;
    logic [CNT_W-1:0]  fifo_count;
    logic              head_valid;
    logic              issue;
    logic              pop;

    // Credits count both buffered beats and the read still inside the RAM.
    assign issue      = (state_q == ISSUE) &&
                        ((32'(fifo_count) + 32'(inflight_q)) < FIFO_DEPTH);
    assign head_valid = (fifo_count != '0);
    assign pop        = head_valid && bus.out_rdy;
    assign push_entry = '{data: bus.bram_do, par: bus.bram_dop, last: inflight_last_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue && (rem_q == '0);
            case (state_q)
                IDLE: begin
                    if (bus.cmd_val) begin
                        state_q <= ISSUE;
                        addr_q  <= bus.cmd_addr;
                        rem_q   <= bus.cmd_cnt;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr_q <= addr_q + 1'b1;
                        rem_q  <= rem_q - 1'b1;
                        if (rem_q == '0) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head.last) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    bram9_rd_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    assign bus.cmd_rdy   = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign bus.bram_en   = issue;
    assign bus.bram_we   = 1'b0;
    assign bus.bram_ssr  = 1'b0;
    assign bus.bram_addr = addr_q;
    assign bus.out_val   = head_valid;
    assign bus.out_data  = head.data;
    assign bus.out_par   = head.par;
    assign bus.out_last  = head_valid && head.last;

`ifdef BRAM9_RD_PARITY_CHK_EN
    logic perr;
    logic err_q;

    assign perr = (^{head.data, head.par}) != ODD_PARITY;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state_q == IDLE) && bus.cmd_val) begin
            err_q <= 1'b0;
        end else if (pop && perr) begin
            err_q <= 1'b1;
        end
    end

    assign bus.out_perr = head_valid && perr;
    assign err_sticky   = err_q;
`else
    logic unused_odd_parity;
    assign unused_odd_parity = ODD_PARITY;
    assign bus.out_perr      = 1'b0;
    assign err_sticky        = 1'b0;
`endif

endmodule

// File: tb/tb_bram9_stream_reader.sv
// Scoreboard bench for bram9_stream_reader with a behavioural 2Kx9 RAM.
// Expected bytes come from the bench's own memory image; parity expectations follow BRAM9_RD_PARITY_CHK_EN.
module tb_bram9_stream_reader;

    logic clk;
    logic rst;
    logic err_sticky;
    logic busy;

    bram9_stream_reader_if bus ();

    bram9_stream_reader #(.ODD_PARITY(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .err_sticky (err_sticky),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       last;
        logic       perr;
    } exp_t;

    typedef struct {
        logic [10:0] addr;
        logic [10:0] cnt;
        logic [3:0]  rdy_pat;
        int unsigned exp_lat;
    } vec_t;

    logic [8:0]  mem [2048];
    exp_t        sb [$];
    int unsigned n_vec;
    int unsigned n_err;
    int unsigned cyc;
    int unsigned last_acc_cyc;
    int unsigned issued;
    int unsigned accepted;
    int unsigned cmd_acc;
    logic [10:0] exp_issue_addr;
    logic        prev_hold;
    logic [7:0]  prev_data;
    logic        prev_par;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.bram_en) begin
            bus.bram_do  <= mem[bus.bram_addr][7:0];
            bus.bram_dop <= mem[bus.bram_addr][8];
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            issued    = 0;
            accepted  = 0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_val", bus.out_val, 1'b1);
                chk("hold_data", {bus.out_par, bus.out_data}, {prev_par, prev_data});
            end
            if (bus.bram_en) begin
                chk("credit", (issued - accepted) < 3, 1'b1);
                chk("rd_addr", bus.bram_addr, exp_issue_addr);
                exp_issue_addr = exp_issue_addr + 11'd1;
                issued++;
            end
            if (bus.cmd_val && bus.cmd_rdy) cmd_acc++;
            if (bus.out_val && bus.out_rdy) begin
                accepted++;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_beat: got data %0h expected no beat (cycle %0d)", bus.out_data, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("beat_data", bus.out_data, e.d);
                    chk("beat_par", bus.out_par, e.p);
                    chk("beat_last", bus.out_last, e.last);
                    chk("beat_perr", bus.out_perr, e.perr);
                    if (e.last) last_acc_cyc = cyc;
                end
            end
            prev_hold = bus.out_val && !bus.out_rdy;
            prev_data = bus.out_data;
            prev_par  = bus.out_par;
        end
    end

    task automatic push_exp(input logic [10:0] a, input logic [10:0] c);
        logic [10:0] ad;
        exp_t        e;
        for (int unsigned i = 0; i <= 32'(c); i++) begin
            ad = a + 11'(i);
            e.d    = mem[ad][7:0];
            e.p    = mem[ad][8];
            e.last = (i == 32'(c));
`ifdef BRAM9_RD_PARITY_CHK_EN
            e.perr = ^mem[ad];
`else
            e.perr = 1'b0;
`endif
            sb.push_back(e);
        end
    endtask

    // Drives one command; returns the acceptance cycle. With hold set, cmd_val stays high.
    task automatic issue_cmd(input logic [10:0] a, input logic [10:0] c, input bit hold,
                             output int unsigned t_acc);
        int unsigned guard;
        guard = 0;
        while (!bus.cmd_rdy && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.cmd_rdy) chk("cmd_rdy_timeout", bus.cmd_rdy, 1'b1);
        bus.cmd_val    = 1'b1;
        bus.cmd_addr   = a;
        bus.cmd_cnt    = c;
        exp_issue_addr = a;
        push_exp(a, c);
        t_acc = cyc;
        @(posedge clk); #1;
        if (!hold) bus.cmd_val = 1'b0;
        chk("first_en", bus.bram_en, 1'b1);
        chk("first_addr", bus.bram_addr, a);
        chk("rdy_low", bus.cmd_rdy, 1'b0);
        chk("busy_high", busy, 1'b1);
        chk("err_clr", err_sticky, 1'b0);
    endtask

    task automatic drain(input logic [3:0] pat, input int unsigned limit);
        int unsigned guard;
        guard = 0;
        while (sb.size() != 0 && guard < limit) begin
            bus.out_rdy = pat[guard % 4];
            @(posedge clk); #1;
            guard++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        bus.out_rdy = 1'b1;
    endtask

    vec_t        vecs [6];
    int unsigned t0;
    int unsigned acc0;
    int unsigned guard;

    initial begin
        vecs[0] = '{addr: 11'h010, cnt: 11'd0,   rdy_pat: 4'b1111, exp_lat: 3};
        vecs[1] = '{addr: 11'h7FE, cnt: 11'd3,   rdy_pat: 4'b1111, exp_lat: 6};
        vecs[2] = '{addr: 11'h200, cnt: 11'd15,  rdy_pat: 4'b1001, exp_lat: 0};
        vecs[3] = '{addr: 11'h3F0, cnt: 11'd31,  rdy_pat: 4'b1111, exp_lat: 34};
        vecs[4] = '{addr: 11'h555, cnt: 11'd6,   rdy_pat: 4'b0101, exp_lat: 0};
        vecs[5] = '{addr: 11'h400, cnt: 11'h7FF, rdy_pat: 4'b1111, exp_lat: 2050};

        for (int unsigned i = 0; i < 2048; i++) begin
            logic [7:0] d;
            d = 8'(i * 37 + (i >> 8));
            mem[i] = {^d, d};
        end

        n_vec = 0; n_err = 0; cyc = 0; cmd_acc = 0; last_acc_cyc = 0;
        exp_issue_addr = '0;
        rst = 1'b1;
        bus.cmd_val = 1'b0; bus.cmd_addr = '0; bus.cmd_cnt = '0;
        bus.out_rdy = 1'b0; bus.bram_do = '0; bus.bram_dop = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_cmd_rdy", bus.cmd_rdy, 1'b1);
        chk("rst_bram_en", bus.bram_en, 1'b0);
        chk("rst_bram_addr", bus.bram_addr, 11'h000);
        chk("rst_out_val", bus.out_val, 1'b0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_out_perr", bus.out_perr, 1'b0);
        chk("rst_err", err_sticky, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", {bus.out_par, bus.out_data}, 9'h000);
        chk("we_ssr", {bus.bram_we, bus.bram_ssr}, 2'b00);
        bus.out_rdy = 1'b1;

        for (int unsigned v = 0; v < 6; v++) begin
            issue_cmd(vecs[v].addr, vecs[v].cnt, 1'b0, t0);
            drain(vecs[v].rdy_pat, 4 * (32'(vecs[v].cnt) + 1) + 50);
            chk("rdy_after", bus.cmd_rdy, 1'b1);
            if (vecs[v].exp_lat != 0) chk("last_cyc", last_acc_cyc, t0 + vecs[v].exp_lat);
        end

        // Parity: A5 with parity 1 is an even-parity error, A5 with parity 0 is clean.
        mem[11'h100] = 9'h1A5;
        mem[11'h101] = 9'h0A5;
        issue_cmd(11'h100, 11'd1, 1'b0, t0);
        drain(4'b1111, 50);
`ifdef BRAM9_RD_PARITY_CHK_EN
        chk("err_sticky_set", err_sticky, 1'b1);
`else
        chk("err_sticky_off", err_sticky, 1'b0);
`endif
        repeat (3) @(posedge clk);
        #1;
`ifdef BRAM9_RD_PARITY_CHK_EN
        chk("err_sticky_hold", err_sticky, 1'b1);
`else
        chk("err_sticky_off2", err_sticky, 1'b0);
`endif

        // Reset after 5 of 20 bytes, then a clean burst.
        acc0 = accepted;
        issue_cmd(11'h080, 11'd19, 1'b0, t0);
        guard = 0;
        while (accepted - acc0 < 5 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("mid_accepts", accepted - acc0, 5);
        rst = 1'b1;
        bus.out_rdy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        chk("mr_cmd_rdy", bus.cmd_rdy, 1'b1);
        chk("mr_bram_en", bus.bram_en, 1'b0);
        chk("mr_bram_addr", bus.bram_addr, 11'h000);
        chk("mr_out_val", bus.out_val, 1'b0);
        chk("mr_out_last", bus.out_last, 1'b0);
        chk("mr_out_perr", bus.out_perr, 1'b0);
        chk("mr_err", err_sticky, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_out_data", {bus.out_par, bus.out_data}, 9'h000);
        bus.out_rdy = 1'b1;
        issue_cmd(11'h0C0, 11'd9, 1'b0, t0);
        drain(4'b1111, 100);
        chk("post_rst_lat", last_acc_cyc, t0 + 12);

        // Command held high through a burst: accepted again only at the first IDLE cycle.
        acc0 = cmd_acc;
        issue_cmd(11'h300, 11'd7, 1'b1, t0);
        guard = 0;
        while (!bus.cmd_rdy && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("held_rdy_cyc", cyc, t0 + 11);
        chk("held_sb_empty", sb.size(), 0);
        exp_issue_addr = 11'h300;
        push_exp(11'h300, 11'd7);
        @(posedge clk); #1;
        bus.cmd_val = 1'b0;
        drain(4'b1111, 100);
        repeat (5) @(posedge clk);
        #1;
        chk("held_accepts", cmd_acc - acc0, 2);
        chk("held_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bram9_stream_reader.md
# bram9_stream_reader

Streaming read-side client for the 2K×9 dual-port block RAM (8 data + 1 parity bit per location). Accepts a burst command (start address, byte count), drives the RAM's read port, and returns bytes on a valid/ready stream with a last marker. It absorbs the RAM's one-cycle read latency and downstream backpressure without losing or duplicating bytes. It is the consumer paired with the writer that owns the other RAM port.

## Interface
Parameters:
- ODD_PARITY, 0, parity sense of the stored parity bit: 0 = even, 1 = odd.

Ports:
- clk  in  1  single clock; also drives the RAM read-port clock.
- rst  in  1  reset; synchronous, active-high.
- cmd_val  in  1  command valid.
- cmd_rdy  out  1  command ready; high only in IDLE.
- cmd_addr  in  11  start address.
- cmd_cnt  in  11  byte count minus 1, giving 1..2048 bytes.
- bram_en  out  1  RAM read-port enable.
- bram_we  out  1  constant 0.
- bram_ssr  out  1  constant 0.
- bram_addr  out  11  RAM read address.
- bram_do  in  8  RAM read data, valid the cycle after bram_en.
- bram_dop  in  1  RAM read parity, same timing as bram_do.
- out_val  out  1  stream valid.
- out_rdy  in  1  stream ready.
- out_data  out  8  byte.
- out_par  out  1  stored parity bit, passed through.
- out_last  out  1  final byte of the burst.
- out_perr  out  1  parity mismatch on this byte (see Configuration).
- err_sticky  out  1  any parity error in the current or most recent burst.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, ISSUE, DRAIN.
  - IDLE→ISSUE on cmd_val&cmd_rdy: latch addr, remaining = cmd_cnt, clear err_sticky.
  - ISSUE→DRAIN in the cycle the final read is issued.
  - DRAIN→IDLE in the cycle the out_last byte is accepted (out_val&out_rdy&out_last).
- Read issue:
  - bram_en = state==ISSUE && (fifo_count + inflight) < 3.
  - No combinational path from out_rdy to bram_en.
  - On issue: addr increments mod 2048 (2047 wraps to 0) and remaining decrements.
  - The final issue is the one with remaining==0. That read is tagged last.
- inflight is a 1-bit register, set to bram_en. In the following cycle, {bram_do, bram_dop, last tag} is pushed into the 3-entry FIFO.
- The FIFO head drives out_*. Pop on out_val&out_rdy.
- out_val and out_data hold stable while out_rdy is low.
- Simultaneous push and pop in one cycle: count unchanged.
- A command with cmd_val high outside IDLE is ignored (cmd_rdy=0). The next command is accepted in the IDLE cycle after the last pop at the earliest.
- Reset mid-burst: return to IDLE, flush the FIFO, discard the in-flight read, clear err_sticky.

## Timing
- Reset values of outputs: cmd_rdy=1, bram_en=0, bram_addr=0, out_val=0, out_last=0, out_perr=0, err_sticky=0, busy=0. out_data and out_par are 0.
- Command accepted at cycle T:
  - First bram_en at T+1.
  - RAM data at T+2, pushed at the end of T+2.
  - out_val at T+3.
- With out_rdy held high, throughput is 1 byte/cycle. A burst of N bytes ends with out_last accepted at T+2+N. cmd_rdy is high at T+3+N.
- Under backpressure, at most 3 bytes are buffered. Issue resumes the cycle after a pop frees a credit.

## Configuration
- Macro `BRAM9_RD_PARITY_CHK_EN`.
- Defined:
  - out_perr = (^{out_data, out_par}) != ODD_PARITY, evaluated on the FIFO head.
  - err_sticky sets on any accepted byte with out_perr=1.
- Undefined:
  - out_perr and err_sticky are tied to 0. No checker logic is built.
  - out_par is still passed through.

## Structure
- Package bram9_rd_pkg holds:
  - the state enum (IDLE/ISSUE/DRAIN);
  - localparams: ADDR_W=11, DATA_W=8, FIFO_DEPTH=3;
  - the FIFO entry struct {data, par, last}.
- Sub-module bram9_rd_fifo: 3-entry synchronous FIFO with count output, same clk/rst. Top level holds the FSM, address counter, credit logic and parity checker.

## Test plan
- Single byte: cmd_addr=0x010, cmd_cnt=0, out_rdy=1. bram_en at T+1 with addr 0x010. One beat at T+3 with out_last=1. cmd_rdy high at T+4.
- Wrap: cmd_addr=0x7FE, cmd_cnt=3. Read addresses are 0x7FE, 0x7FF, 0x000, 0x001. 4 beats in order, last on the 4th.
- Backpressure: 16-byte burst with out_rdy toggled 1-0-0-1 repeating. No lost or duplicated bytes, never more than 3 buffered, bram_en never asserted with credits exhausted.
- Parity (macro defined, ODD_PARITY=0): byte 0xA5 with parity 1 gives out_perr=1 and err_sticky=1 until the next cmd accept. Byte 0xA5 with parity 0 gives out_perr=0.
- Reset mid-burst: rst for 1 cycle after 5 of 20 bytes. All outputs return to reset values next cycle. A new command then streams cleanly.
- Command while busy: cmd_val held during a burst is not accepted until IDLE. Exactly one subsequent burst follows.
